// File: rtl/node_stream_pkg.sv
// Purpose: shared types and constants for the node snapshot streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package node_stream_pkg;

    // Streamer control states: waiting for a request, or draining a frame.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    localparam int COORD_W_DEF = 32;
    localparam int FRAME_CNT_W = 16;
    localparam int DROP_CNT_W  = 8;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Index width that still works for the degenerate single-bit case.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/node_snapshot_streamer_buffer.sv
// Purpose: frame buffer holding one coherent (x, y) snapshot of every node.
// Latency: parallel load on load_en edge; indexed read is combinational.
// Backpressure: none; contents hold until the next load.
module snapshot_buffer
    import node_stream_pkg::*;
#(
    parameter int NODE_COUNT = 10,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int IDX_W      = idx_width(NODE_COUNT)
) (
    input  logic                          clk,
    input  logic                          load_en,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [COORD_W-1:0]            rd_x,
    output logic [COORD_W-1:0]            rd_y
);

    logic [COORD_W-1:0] mem_x [NODE_COUNT];
    logic [COORD_W-1:0] mem_y [NODE_COUNT];

    // Capture every node in the same edge so the frame is coherent; no reset
    // because the contents are only read after a load.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                mem_x[i] <= nodes_x[i*COORD_W +: COORD_W];
                mem_y[i] <= nodes_y[i*COORD_W +: COORD_W];
            end
        end
    end

    // Select the addressed pair; indices past the last node read as zero.
    always_comb begin
        rd_x = '0;
        rd_y = '0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_x = mem_x[i];
                rd_y = mem_y[i];
            end
        end
    end

endmodule

// File: rtl/node_snapshot_streamer.sv
// Purpose: snapshot all node positions on request and stream them one per beat.
// Latency: first beat visible 1 cycle after the capture edge; 1 beat/cycle max.
// Backpressure: valid/ready; beat holds while out_ready=0, requests while busy are dropped.
module node_snapshot_streamer
    import node_stream_pkg::*;
#(
    parameter int NODE_COUNT = 10,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int IDX_W      = idx_width(NODE_COUNT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
    input  logic                          snap_req,
    output logic                          snap_busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COORD_W-1:0]            out_x,
    output logic [COORD_W-1:0]            out_y,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic [FRAME_CNT_W-1:0]        frame_count,
    output logic [DROP_CNT_W-1:0]         drop_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);

    stream_state_t          state_q;
    logic                   busy_q;
    logic [IDX_W-1:0]       idx_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [DROP_CNT_W-1:0]  drop_cnt_q;

    logic                   load_en;
    logic                   at_last;
    logic [COORD_W-1:0]     rd_x;
    logic [COORD_W-1:0]     rd_y;

    // A capture only happens from IDLE, and reset suppresses it outright.
    assign load_en = (state_q == IDLE) && snap_req && !reset;
    assign at_last = (idx_q == LAST_IDX);

    snapshot_buffer #(
        .NODE_COUNT (NODE_COUNT),
        .COORD_W    (COORD_W),
        .IDX_W      (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .load_en (load_en),
        .nodes_x (nodes_x),
        .nodes_y (nodes_y),
        .rd_idx  (idx_q),
        .rd_x    (rd_x),
        .rd_y    (rd_y)
    );

    // Control FSM: index, busy flag and statistics all advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snap_req) begin
                        state_q <= STREAM;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                STREAM: begin
                    // Any request seen while a frame is in flight is lost,
                    // including one landing on the final transfer.
                    if (snap_req && (drop_cnt_q != DROP_CNT_MAX)) begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                    if (out_ready) begin
                        if (at_last) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            idx_q       <= '0;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Beat payload is forced to zero whenever nothing is presented.
    always_comb begin
        out_x     = '0;
        out_y     = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (busy_q) begin
            out_x     = rd_x;
            out_y     = rd_y;
            out_index = idx_q;
            out_last  = at_last;
        end
    end

    assign out_valid   = busy_q;
    assign snap_busy   = busy_q;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_node_snapshot_streamer.sv
module tb_node_snapshot_streamer;

    localparam int NODE_COUNT = 10;
    localparam int COORD_W    = 32;
    localparam int IDX_W      = $clog2(NODE_COUNT);

    logic                          clk;
    logic                          reset;
    logic [NODE_COUNT*COORD_W-1:0] nodes_x;
    logic [NODE_COUNT*COORD_W-1:0] nodes_y;
    logic                          snap_req;
    logic                          snap_busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [COORD_W-1:0]            out_x;
    logic [COORD_W-1:0]            out_y;
    logic [IDX_W-1:0]              out_index;
    logic                          out_last;
    logic [15:0]                   frame_count;
    logic [7:0]                    drop_count;

    node_snapshot_streamer #(
        .NODE_COUNT (NODE_COUNT),
        .COORD_W    (COORD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nodes_x     (nodes_x),
        .nodes_y     (nodes_y),
        .snap_req    (snap_req),
        .snap_busy   (snap_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_index   (out_index),
        .out_last    (out_last),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a frame is a queue of captured pairs, popped per transfer.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } beat_t;

    beat_t       m_q[$];
    bit          m_busy;
    logic [15:0] m_frames;
    logic [7:0]  m_drops;

    int tests;
    int fails;
    int dut_xfers;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit req, input bit rdy, input bit rst);
        beat_t b;
        if (rst) begin
            m_busy   = 1'b0;
            m_q.delete();
            m_frames = 16'd0;
            m_drops  = 8'd0;
        end else if (!m_busy) begin
            if (req) begin
                for (int i = 0; i < NODE_COUNT; i++) begin
                    b.x = nodes_x[i*COORD_W +: COORD_W];
                    b.y = nodes_y[i*COORD_W +: COORD_W];
                    m_q.push_back(b);
                end
                m_busy = 1'b1;
            end
        end else begin
            if (req && m_drops != 8'hFF) m_drops = m_drops + 8'd1;
            if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy   = 1'b0;
                    m_frames = m_frames + 16'd1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [COORD_W-1:0] ex, ey;
        int                 ei;
        bit                 el;
        ex = '0; ey = '0; ei = 0; el = 1'b0;
        if (m_busy) begin
            ex = m_q[0].x;
            ey = m_q[0].y;
            ei = NODE_COUNT - m_q.size();
            el = (m_q.size() == 1);
        end
        check("out_valid",   {63'd0, out_valid}, {63'd0, m_busy});
        check("snap_busy",   {63'd0, snap_busy}, {63'd0, m_busy});
        check("out_x",       64'(out_x), 64'(ex));
        check("out_y",       64'(out_y), 64'(ey));
        check("out_index",   64'(out_index), 64'(ei));
        check("out_last",    {63'd0, out_last}, {63'd0, el});
        check("frame_count", 64'(frame_count), 64'(m_frames));
        check("drop_count",  64'(drop_count), 64'(m_drops));
    endtask

    // Drive inputs for one edge (called at a negedge), then sample at the next negedge.
    task automatic tick(input bit req, input bit rdy, input bit rst);
        snap_req  = req;
        out_ready = rdy;
        reset     = rst;
        if (!rst && out_valid && out_ready) dut_xfers++;
        model_edge(req, rdy, rst);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic randomize_nodes();
        for (int i = 0; i < NODE_COUNT; i++) begin
            nodes_x[i*COORD_W +: COORD_W] = $urandom;
            nodes_y[i*COORD_W +: COORD_W] = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 40) begin
            tick(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("drain_done", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0; fails = 0; dut_xfers = 0;
        m_busy = 1'b0; m_frames = 16'd0; m_drops = 8'd0;
        reset = 1'b1; snap_req = 1'b0; out_ready = 1'b0;
        nodes_x = '0; nodes_y = '0;
        @(negedge clk);

        // Reset state
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("rst_frame", 64'(frame_count), 64'd0);
        tick(1'b0, 1'b1, 1'b0);

        // Basic capture with recognisable values
        for (int i = 0; i < NODE_COUNT; i++) begin
            nodes_x[i*COORD_W +: COORD_W] = 32'h100 + 32'(i);
            nodes_y[i*COORD_W +: COORD_W] = 32'h200 + 32'(i);
        end
        tick(1'b1, 1'b1, 1'b0);
        check("basic_first_valid", {63'd0, out_valid}, 64'd1);
        check("basic_first_x", 64'(out_x), 64'h100);
        check("basic_first_idx", 64'(out_index), 64'd0);
        for (int b = 0; b < NODE_COUNT; b++) begin
            check("basic_x", 64'(out_x), 64'(32'h100 + 32'(b)));
            check("basic_y", 64'(out_y), 64'(32'h200 + 32'(b)));
            check("basic_last", {63'd0, out_last}, {63'd0, (b == NODE_COUNT - 1)});
            tick(1'b0, 1'b1, 1'b0);
        end
        check("basic_done_valid", {63'd0, snap_busy}, 64'd0);
        check("basic_frames", 64'(frame_count), 64'd1);

        // Back-pressure with inputs changing every cycle after capture
        randomize_nodes();
        tick(1'b1, 1'b0, 1'b0);
        dut_xfers = 0;
        for (int p = 0; p < 60 && m_busy; p++) begin
            randomize_nodes();
            tick(1'b0, (p % 3) == 0, 1'b0);
        end
        check("bp_xfers", 64'(dut_xfers), 64'd10);
        check("bp_frames", 64'(frame_count), 64'd2);
        tick(1'b0, 1'b1, 1'b0);

        // Drops: two mid-frame and one on the final transfer
        randomize_nodes();
        tick(1'b1, 1'b1, 1'b0);
        for (int b = 0; b < NODE_COUNT; b++) begin
            tick((b == 2) || (b == 5) || (b == NODE_COUNT - 1), 1'b1, 1'b0);
        end
        check("drop_three", 64'(drop_count), 64'd3);
        check("drop_frames", 64'(frame_count), 64'd3);
        tick(1'b0, 1'b1, 1'b0);
        check("drop_no_frame", {63'd0, out_valid}, 64'd0);

        // Drop counter saturation
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) tick(1'b1, 1'b0, 1'b0);
        check("drop_sat", 64'(drop_count), 64'hFF);
        drain();
        tick(1'b0, 1'b1, 1'b0);

        // Reset mid-stream after beat 4 transfers
        randomize_nodes();
        tick(1'b1, 1'b1, 1'b0);
        for (int b = 0; b < 5; b++) tick(1'b0, 1'b1, 1'b0);
        check("mid_idx_before", 64'(out_index), 64'd5);
        tick(1'b0, 1'b1, 1'b1);
        check("mid_valid", {63'd0, out_valid}, 64'd0);
        check("mid_frames", 64'(frame_count), 64'd0);
        check("mid_drops", 64'(drop_count), 64'd0);
        randomize_nodes();
        tick(1'b1, 1'b1, 1'b0);
        check("mid_restart_idx", 64'(out_index), 64'd0);
        drain();
        check("mid_restart_frames", 64'(frame_count), 64'd1);

        // Reset takes priority over a simultaneous request
        tick(1'b1, 1'b1, 1'b1);
        check("prio_valid", {63'd0, out_valid}, 64'd0);
        check("prio_drops", 64'(drop_count), 64'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("prio_still_idle", {63'd0, snap_busy}, 64'd0);

        // Randomized soak against the model
        for (int c = 0; c < 600; c++) begin
            randomize_nodes();
            tick($urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1,
                 $urandom_range(149, 0) == 0);
        end
        drain();
        tick(1'b0, 1'b1, 1'b0);

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_frames = 16'hFFFF;
        check("wrap_preset", 64'(frame_count), 64'hFFFF);
        randomize_nodes();
        tick(1'b1, 1'b1, 1'b0);
        drain();
        check("wrap_zero", 64'(frame_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
